// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the windowed register file.
//  - Default geometry (data width, window-relative address width, window count)
//    and the derived current-window-pointer width.
//  - win_state_t: window controller occupancy state.
//  - phys_idx(): maps (cwp, window-relative address) to a flat storage index.
//    Address 0 is the single global register, shared by every window, and sits
//    at index 0. Each window then owns 2**reg_aw-1 private words, packed back to back.
package regfile_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_REG_AW  = 2;
   localparam int DEF_NUM_WIN = 4;
   localparam int DEF_WIN_AW  = $clog2(DEF_NUM_WIN);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      NESTED = 2'd1,
      FULL   = 2'd2
   } win_state_t;

   function automatic int phys_idx(input int cwp, input int addr, input int reg_aw);
      int priv_per_win;
      priv_per_win = (1 << reg_aw) - 1;
      if (addr == 0) return 0;
      return 1 + cwp * priv_per_win + (addr - 1);
   endfunction

endpackage

// File: rtl/windowed_regfile_win_ctrl.sv
// win_ctrl: current-window pointer and nesting-depth controller.
//  Ports:
//   clk, rst        clock, synchronous active-high reset
//   win_call        request to open a new window (cwp+1)
//   win_ret         request to return to the previous window (cwp-1)
//   cwp             current window pointer, wraps modulo NUM_WIN
//   win_depth       outstanding nested calls, saturates (never wraps)
//   win_overflow    one-cycle pulse after a refused call
//   win_underflow   one-cycle pulse after a refused return
//  Occupancy is tracked as EMPTY / NESTED / FULL; the state alone decides
//  whether a call or a return may be accepted.
module win_ctrl
   import regfile_pkg::*;
#(
   parameter int NUM_WIN = DEF_NUM_WIN,
   parameter int WIN_AW  = DEF_WIN_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              win_call,
   input  logic              win_ret,
   output logic [WIN_AW-1:0] cwp,
   output logic [WIN_AW-1:0] win_depth,
   output logic              win_overflow,
   output logic              win_underflow
);

   localparam logic [WIN_AW-1:0] MAX_DEPTH = WIN_AW'(NUM_WIN - 1);

   win_state_t        state_q, state_d;
   logic [WIN_AW-1:0] cwp_q, cwp_d;
   logic [WIN_AW-1:0] depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic call_only, ret_only;

   // A simultaneous call and return cancel out: nothing moves, no flag.
   assign call_only = win_call & ~win_ret;
   assign ret_only  = win_ret & ~win_call;

   always_comb begin
      cwp_d   = cwp_q;
      depth_d = depth_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (call_only) begin
         if (state_q != FULL) begin
            cwp_d   = cwp_q + 1'b1;
            depth_d = depth_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (ret_only) begin
         if (state_q != EMPTY) begin
            cwp_d   = cwp_q - 1'b1;
            depth_d = depth_q - 1'b1;
         end else begin
            unf_d = 1'b1;
         end
      end
      if (depth_d == '0)            state_d = EMPTY;
      else if (depth_d == MAX_DEPTH) state_d = FULL;
      else                          state_d = NESTED;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         cwp_q   <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cwp_q   <= cwp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign cwp           = cwp_q;
   assign win_depth     = depth_q;
   assign win_overflow  = ovf_q;
   assign win_underflow = unf_q;

endmodule

// File: rtl/windowed_regfile.sv
// windowed_regfile: NUM_WIN register windows of 2**REG_AW entries, two
// combinational read ports and one synchronous write port.
//  Ports:
//   clk, rst            clock, synchronous active-high reset (clears all state)
//   rr1, rr2, wr        window-relative read/write addresses
//   data_in             write data
//   regfile_write       write enable
//   win_call, win_ret   window push / pop pulses
//   r1, r2              read data (current window, zero latency)
//   cwp, win_depth      current window pointer and nesting depth
//   win_overflow        one-cycle pulse: call refused
//   win_underflow       one-cycle pulse: return refused
//  Address 0 always selects one global register shared by all windows.
//  Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read that hits
//  the word being written this cycle returns data_in (write-through).
//  Writes always use the window pointer from before any same-cycle call/ret.
module windowed_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_AW  = DEF_REG_AW,
   parameter int NUM_WIN = DEF_NUM_WIN,
   parameter int WIN_AW  = $clog2(NUM_WIN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rr1,
   input  logic [REG_AW-1:0] rr2,
   input  logic [REG_AW-1:0] wr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              regfile_write,
   input  logic              win_call,
   input  logic              win_ret,
   output logic [DATA_W-1:0] r1,
   output logic [DATA_W-1:0] r2,
   output logic [WIN_AW-1:0] cwp,
   output logic [WIN_AW-1:0] win_depth,
   output logic              win_overflow,
   output logic              win_underflow
);

   localparam int NWORDS = 1 + NUM_WIN * ((2 ** REG_AW) - 1);
   localparam int IDX_W  = $clog2(NWORDS);

   logic [DATA_W-1:0] mem_q [NWORDS];
   logic [DATA_W-1:0] mem_d [NWORDS];

   logic [IDX_W-1:0] widx, ridx1, ridx2;

   win_ctrl #(
      .NUM_WIN (NUM_WIN),
      .WIN_AW  (WIN_AW)
   ) u_win_ctrl (
      .clk           (clk),
      .rst           (rst),
      .win_call      (win_call),
      .win_ret       (win_ret),
      .cwp           (cwp),
      .win_depth     (win_depth),
      .win_overflow  (win_overflow),
      .win_underflow (win_underflow)
   );

   assign widx  = IDX_W'(phys_idx(int'(cwp), int'(wr),  REG_AW));
   assign ridx1 = IDX_W'(phys_idx(int'(cwp), int'(rr1), REG_AW));
   assign ridx2 = IDX_W'(phys_idx(int'(cwp), int'(rr2), REG_AW));

   always_comb begin
      mem_d = mem_q;
      if (regfile_write) mem_d[widx] = data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) mem_q <= '{default: '0};
      else     mem_q <= mem_d;
   end

   always_comb begin
      r1 = mem_q[ridx1];
      r2 = mem_q[ridx2];
`ifdef REGFILE_BYPASS_EN
      if (regfile_write && (ridx1 == widx)) r1 = data_in;
      if (regfile_write && (ridx2 == widx)) r2 = data_in;
`endif
   end

endmodule

// File: tb/tb_windowed_regfile.sv
// Directed testbench for windowed_regfile (default geometry: 16-bit data,
// 4 registers per window, 4 windows). Honours REGFILE_BYPASS_EN.
module tb_windowed_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rr1, rr2, wr;
   logic [15:0] data_in;
   logic        regfile_write, win_call, win_ret;
   logic [15:0] r1, r2;
   logic [1:0]  cwp, win_depth;
   logic        win_overflow, win_underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   windowed_regfile dut (
      .clk           (clk),
      .rst           (rst),
      .rr1           (rr1),
      .rr2           (rr2),
      .wr            (wr),
      .data_in       (data_in),
      .regfile_write (regfile_write),
      .win_call      (win_call),
      .win_ret       (win_ret),
      .r1            (r1),
      .r2            (r2),
      .cwp           (cwp),
      .win_depth     (win_depth),
      .win_overflow  (win_overflow),
      .win_underflow (win_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regfile_write = 1'b0;
      win_call      = 1'b0;
      win_ret       = 1'b0;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
      wr = a; data_in = d; regfile_write = 1'b1;
      tick();
      idle();
   endtask

   task automatic call();
      win_call = 1'b1; tick(); idle();
   endtask

   task automatic ret();
      win_ret = 1'b1; tick(); idle();
   endtask

   initial begin
      rst = 1'b1; rr1 = '0; rr2 = '0; wr = '0; data_in = '0;
      idle();
      // Activity during reset must be discarded.
      regfile_write = 1'b1; wr = 2'd1; data_in = 16'hFFFF; win_call = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      #1;
      for (int a = 0; a < 4; a++) begin
         rr1 = 2'(a); rr2 = 2'(3 - a);
         #1;
         chk($sformatf("rst_r1_a%0d", a), 32'(r1), 32'h0);
         chk($sformatf("rst_r2_a%0d", 3 - a), 32'(r2), 32'h0);
      end
      chk("rst_cwp", 32'(cwp), 32'd0);
      chk("rst_depth", 32'(win_depth), 32'd0);
      chk("rst_ovf", 32'(win_overflow), 32'd0);
      chk("rst_unf", 32'(win_underflow), 32'd0);

      // Window isolation.
      write_reg(2'd2, 16'h000A);
      call();
      chk("iso_cwp1", 32'(cwp), 32'd1);
      chk("iso_depth1", 32'(win_depth), 32'd1);
      rr1 = 2'd2; #1;
      chk("iso_new_win_empty", 32'(r1), 32'h0);
      write_reg(2'd2, 16'h00B0);
      chk("iso_new_win", 32'(r1), 32'h00B0);
      ret();
      chk("iso_ret_cwp", 32'(cwp), 32'd0);
      chk("iso_old_win", 32'(r1), 32'h000A);

      // Global register visible in every window.
      write_reg(2'd0, 16'h1234);
      rr2 = 2'd0; #1;
      chk("glob_w0", 32'(r2), 32'h1234);
      call();
      chk("glob_w1", 32'(r2), 32'h1234);
      call();
      chk("glob_cwp2", 32'(cwp), 32'd2);
      chk("glob_w2", 32'(r2), 32'h1234);

      // Fill to the top, then one refused call.
      call();
      chk("full_cwp", 32'(cwp), 32'd3);
      chk("full_depth", 32'(win_depth), 32'd3);
      chk("full_no_ovf", 32'(win_overflow), 32'd0);
      chk("glob_w3", 32'(r2), 32'h1234);
      call();
      chk("ovf_pulse", 32'(win_overflow), 32'd1);
      chk("ovf_cwp", 32'(cwp), 32'd3);
      chk("ovf_depth", 32'(win_depth), 32'd3);
      tick();
      chk("ovf_clear", 32'(win_overflow), 32'd0);

      // Unwind, then one refused return.
      ret(); ret(); ret();
      chk("unw_cwp", 32'(cwp), 32'd0);
      chk("unw_depth", 32'(win_depth), 32'd0);
      chk("unw_no_unf", 32'(win_underflow), 32'd0);
      ret();
      chk("unf_pulse", 32'(win_underflow), 32'd1);
      chk("unf_cwp", 32'(cwp), 32'd0);
      chk("unf_depth", 32'(win_depth), 32'd0);
      tick();
      chk("unf_clear", 32'(win_underflow), 32'd0);

      // Call and return together: ignored, no flags.
      win_call = 1'b1; win_ret = 1'b1; tick(); idle();
      chk("both_cwp", 32'(cwp), 32'd0);
      chk("both_unf", 32'(win_underflow), 32'd0);
      chk("both_ovf", 32'(win_overflow), 32'd0);

      // Write in the same cycle as a call lands in the old window.
      call();
      chk("wc_cwp1", 32'(cwp), 32'd1);
      wr = 2'd1; data_in = 16'h0055; regfile_write = 1'b1; win_call = 1'b1;
      tick(); idle();
      chk("wc_cwp2", 32'(cwp), 32'd2);
      rr1 = 2'd1; #1;
      chk("wc_new_win_r1", 32'(r1), 32'h0);
      ret();
      chk("wc_ret_cwp", 32'(cwp), 32'd1);
      chk("wc_old_win_r1", 32'(r1), 32'h0055);

      // Same-cycle read of the word being written.
      rr1 = 2'd3; rr2 = 2'd3; wr = 2'd3; data_in = 16'hBEEF; regfile_write = 1'b1;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_r1_same", 32'(r1), 32'hBEEF);
      chk("byp_r2_same", 32'(r2), 32'hBEEF);
`else
      chk("byp_r1_same", 32'(r1), 32'h0);
      chk("byp_r2_same", 32'(r2), 32'h0);
`endif
      tick(); idle();
      chk("byp_r1_next", 32'(r1), 32'hBEEF);
      chk("byp_r2_next", 32'(r2), 32'hBEEF);
      ret();
      chk("byp_w0_r3", 32'(r1), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
